rr_hold_arbiter: RTL
====================

# rr_hold_arbiter

Round-robin arbiter with grant hold, sharing one downstream resource between N requesters. It builds on the team's fixed-priority shift_req/shift_grant scheme by adding a rotating priority pointer, a registered one-hot grant with an encoded owner index, owner-controlled release and a hold-limit timeout against starvation. It sits between the requesting engines and the shared resource's select mux.

## Interface
- N, 4, number of requesters; supported range 2..16
- MAX_HOLD, 8, maximum consecutive grant cycles per tenure; range 1..255
- IW, $clog2(N), width of grant_id (derived, not overridden)
- clk  input  1  single clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- req  input  N  request per requester; level, held until served
- done  input  N  release pulse from the current owner; ignored on non-owner bits
- grant  output  N  registered one-hot grant; all zero when idle
- grant_valid  output  1  high whenever any grant bit is high
- grant_id  output  IW  binary index of the granted requester; 0 when idle

## Operation
- States: IDLE (no owner) and BUSY (owner held in register `owner`).
- Pointer `ptr` (IW bits) marks the highest-priority index. Priority order is ptr, ptr+1, …, ptr+N-1 mod N.
- Winner selection is combinational:
  - rotate req right by ptr;
  - apply a fixed lowest-index-first priority pick;
  - rotate the one-hot result left by ptr;
  - encode the result to an index.
- IDLE: if req != 0, load the winner into grant/owner, set hold_cnt=1, ptr=winner+1 mod N, and go to BUSY. Otherwise stay in IDLE with outputs zero.
- BUSY: release occurs when any of the following holds:
  - done[owner]=1;
  - req[owner]=0;
  - hold_cnt==MAX_HOLD.
  Otherwise hold_cnt increments and grant stays unchanged.
- On release, in the same edge:
  - if req with the owner bit masked is nonzero, grant the new winner (back-to-back handoff, no idle cycle), set hold_cnt=1, and update ptr;
  - else if the owner is still requesting (timeout or done with req high), regrant the owner with hold_cnt=1 and ptr=owner+1;
  - else go to IDLE and clear grant.
- Masking the owner during handoff guarantees that a timed-out owner yields whenever anyone else waits.
- hold_cnt is 8 bits and saturates at MAX_HOLD; it never wraps.
- done on a non-owner bit, or done while IDLE, has no effect.
- Simultaneous done[owner] and a new req from another requester: handoff to the rotated winner on that edge.

## Timing
- Reset (rst=1 at an edge): grant=0, grant_valid=0, grant_id=0, ptr=0, owner=0, hold_cnt=0, state=IDLE. rst overrides all other inputs.
- Reset asserted mid-tenure drops the grant on the next edge; there is no drain.
- Latency is 1 cycle: a req sampled at edge t in IDLE gives grant high after edge t.
- Release is evaluated on req/done sampled at edge t. The old grant is low and the new grant high after edge t; the bus is never without an owner while others request.
- Maximum tenure is MAX_HOLD cycles.
- Worst-case wait for a continuously requesting input is (N-1)*MAX_HOLD cycles after its req is sampled.
- Outputs are registered only; there is no combinational path from req/done to grant.
- Invariant: grant is always one-hot or zero, and grant_valid == |grant.

## Test plan
- **Reset/idle:** rst=1 for 2 cycles with req=4'b1111 -> grant=0, grant_id=0. Release rst with req=4'b1111 -> after 1 edge grant=4'b0001, grant_id=0.
- **Rotation:** req=4'b1111 held, each owner pulses done on its 2nd grant cycle -> grant sequence 0001, 0010, 0100, 1000, 0001, with 2 cycles per owner and no gap cycles.
- **Timeout:** MAX_HOLD=8, req=4'b0011, no done -> requester 0 granted exactly 8 cycles, then requester 1 for 8, then 0 again.
- **Sole requester:** req=4'b0100 only, no done -> grant stays 0100 continuously (regrant at each timeout, hold_cnt restarts at 1). Drop req -> grant=0 after 1 edge.
- **Ignored inputs:** owner=1, pulse done[3] and done[0] -> grant unchanged. Pulse done[1] with req=4'b1010 -> next grant=4'b1000.
- **Mid-operation reset:** rst asserted while grant=4'b0100 with hold_cnt=5 -> grant=0 after 1 edge. After rst deasserts with req=4'b0101 -> grant=4'b0001 (ptr reset to 0).

Source files
------------

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: round-robin arbiter with grant hold, owner release and hold-limit timeout
module rr_hold_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_id
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, nxt_state;
  logic [IW-1:0] owner, nxt_owner, ptr, nxt_ptr, win;
  logic [7:0] hold_cnt, nxt_cnt;
  logic [N-1:0] others;
  logic rel, take, keep;
  // lowest set bit of req rotated right by p, mapped back to an absolute index
  function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [N-1:0] rot;
    logic [IW:0] s;
    rot = N'({r, r} >> p);
    s = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) s = (IW + 1)'(i);
    s = s + {1'b0, p};
    return (s >= (IW + 1)'(N)) ? IW'(s - (IW + 1)'(N)) : s[IW-1:0];
  endfunction
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
    return (p == IW'(N - 1)) ? '0 : p + IW'(1);
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
      hold_cnt <= '0;
    end else begin
      state <= nxt_state;
      owner <= nxt_owner;
      ptr <= nxt_ptr;
      hold_cnt <= nxt_cnt;
    end
  end
  // masking the owner on handoff makes a timed-out owner yield to any waiter
  always_comb begin
    others = req & ~(N'(1) << owner);
    rel = done[owner] | ~req[owner] | (hold_cnt == 8'(MAX_HOLD));
    win = pick(state == BUSY ? others : req, ptr);
    take = (state == BUSY) ? rel & (|others) : |req;
    keep = (state == BUSY) & rel & ~(|others) & req[owner];
    nxt_state = (take | keep | ((state == BUSY) & ~rel)) ? BUSY : IDLE;
    nxt_owner = take ? win : (nxt_state == BUSY ? owner : '0);
    nxt_cnt = (take | keep) ? 8'd1 : (nxt_state == BUSY ? (hold_cnt < 8'(MAX_HOLD) ? hold_cnt + 8'd1 : hold_cnt) : 8'd0);
    nxt_ptr = take ? inc(win) : (keep ? inc(owner) : ptr);
  end
  always_comb begin
    grant = (state == BUSY) ? N'(1) << owner : '0;
    grant_valid = state == BUSY;
    grant_id = (state == BUSY) ? owner : '0;
  end
endmodule
